// File: rtl/sr_feeder_8x64.sv
// sr_feeder_8x64 -- front-end driver for an 8-bit x SR_DEPTH tapped shift register.
// Buffers upstream bytes in a small FIFO and issues one shift strobe per byte.
// It counts how many real bytes have entered the register and flags which taps
// hold valid data. A flush drains the FIFO and then shifts in SR_DEPTH pad bytes.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_data/in_valid    upstream byte stream
//   in_ready            registered; high while the FIFO can accept a byte
//   hold                downstream stall, suppresses shift and pops
//   flush               single-cycle flush request
//   shift, sr_in        shift strobe and byte to shift in
//   fill_cnt            real bytes shifted in, saturating at SR_DEPTH
//   tap_valid           {sr_out, tap three, tap two, tap one} data-valid flags
//   busy                flush in progress
module sr_feeder_8x64 #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned SR_DEPTH   = 64,
  parameter int unsigned TAP1_LAT   = 16,
  parameter int unsigned TAP2_LAT   = 32,
  parameter int unsigned TAP3_LAT   = 48,
  parameter logic [7:0]  PAD_BYTE   = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       hold,
  input  logic       flush,
  output logic       shift,
  output logic [7:0] sr_in,
  output logic [6:0] fill_cnt,
  output logic [3:0] tap_valid,
  output logic       busy
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = $clog2(SR_DEPTH);

  localparam logic [AW:0]   FIFO_FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [6:0]    FILL_MAX  = 7'(SR_DEPTH);
  localparam logic [6:0]    T1        = 7'(TAP1_LAT);
  localparam logic [6:0]    T2        = 7'(TAP2_LAT);
  localparam logic [6:0]    T3        = 7'(TAP3_LAT);
  localparam logic [PW-1:0] PAD_LAST  = PW'(SR_DEPTH - 1);

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    PAD
  } state_t;

  state_t        state, state_next;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_next;
  logic [PW-1:0] pad_cnt, pad_cnt_next;
  logic [6:0]    fill_next;
  logic [3:0]    tap_next;
  logic          push, pop, pad_shift, pad_done;
  logic          busy_next, ready_next;

  always_comb begin
    push         = in_valid & in_ready;
    pop          = (state != PAD) && (count != '0) && !hold;
    pad_shift    = (state == PAD) && !hold;
    pad_done     = pad_shift && (pad_cnt == '0);
    count_next   = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

    fill_next = fill_cnt;
    if (pop && (fill_cnt < FILL_MAX)) begin
      fill_next = fill_cnt + 7'd1;
    end
    if (pad_done) begin
      fill_next = '0;
    end

    state_next   = state;
    pad_cnt_next = pad_cnt;
    if (pad_shift) begin
      pad_cnt_next = pad_cnt - 1'b1;
    end

    // Flush decisions use post-edge occupancy so a byte accepted alongside
    // the flush is drained before the pad bytes.
    unique case (state)
      RUN: begin
        if (flush) begin
          if (count_next != '0) begin
            state_next = DRAIN;
          end else if (fill_next != '0) begin
            state_next   = PAD;
            pad_cnt_next = PAD_LAST;
          end
        end
      end
      DRAIN: begin
        if (count_next == '0) begin
          state_next   = PAD;
          pad_cnt_next = PAD_LAST;
        end
      end
      PAD: begin
        if (pad_done) begin
          state_next = RUN;
        end
      end
      default: state_next = RUN;
    endcase

    // busy stays high through the final pad pulse; in_ready returns with its fall.
    busy_next  = (state_next != RUN) || pad_done;
    ready_next = (state_next == RUN) && !pad_done && (count_next < FIFO_FULL);
    tap_next   = busy_next ? '0 : {fill_next >= FILL_MAX, fill_next >= T3,
                                   fill_next >= T2, fill_next >= T1};
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      pad_cnt   <= '0;
      shift     <= 1'b0;
      sr_in     <= '0;
      fill_cnt  <= '0;
      tap_valid <= '0;
      busy      <= 1'b0;
      in_ready  <= 1'b0;
    end else begin
      state    <= state_next;
      pad_cnt  <= pad_cnt_next;
      count    <= count_next;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        sr_in  <= mem[rd_ptr];
      end else if (pad_shift) begin
        sr_in  <= PAD_BYTE;
      end
      shift     <= pop | pad_shift;
      fill_cnt  <= fill_next;
      tap_valid <= tap_next;
      busy      <= busy_next;
      in_ready  <= ready_next;
    end
  end

endmodule

// File: tb/tb_sr_feeder_8x64.sv
// Testbench for sr_feeder_8x64: table-driven fill/tap vectors, directed
// flush/hold/reset sequences, and randomized traffic against a queue model.
module tb_sr_feeder_8x64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       hold = 1'b0;
  logic       flush = 1'b0;
  logic       in_ready, shift, busy;
  logic [7:0] sr_in;
  logic [6:0] fill_cnt;
  logic [3:0] tap_valid;

  always #5 clk = ~clk;

  sr_feeder_8x64 #(
    .FIFO_DEPTH(4),
    .SR_DEPTH  (64),
    .TAP1_LAT  (16),
    .TAP2_LAT  (32),
    .TAP3_LAT  (48),
    .PAD_BYTE  (8'h00)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .hold     (hold),
    .flush    (flush),
    .shift    (shift),
    .sr_in    (sr_in),
    .fill_cnt (fill_cnt),
    .tap_valid(tap_valid),
    .busy     (busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: byte queue plus a mode variable, advanced once per edge.
  logic [7:0] q[$];
  int   mmode;      // 0 run, 1 drain, 2 pad
  int   m0;
  int   pads_left;
  int   mfill;
  bit   done, acc;
  bit   e_shift, e_busy, e_ready;
  logic [7:0] e_sr;
  int   e_fill;
  logic [3:0] e_tap;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      mmode = 0; pads_left = 0; mfill = 0;
      e_shift = 0; e_sr = 8'h00; e_fill = 0; e_tap = 4'b0000;
      e_busy = 0; e_ready = 0;
    end else begin
      m0 = mmode;
      done = 0;
      acc = in_valid && e_ready;
      e_shift = 0;
      if (!hold) begin
        if (m0 != 2 && q.size() > 0) begin
          e_sr = q.pop_front();
          e_shift = 1;
          if (mfill < 64) mfill++;
        end else if (m0 == 2) begin
          e_sr = 8'h00;
          e_shift = 1;
          pads_left--;
          if (pads_left == 0) begin
            mfill = 0; mmode = 0; done = 1;
          end
        end
      end
      if (acc) q.push_back(in_data);
      if (m0 == 0 && flush && !e_busy) begin
        if (q.size() > 0) mmode = 1;
        else if (mfill > 0) begin mmode = 2; pads_left = 64; end
      end else if (m0 == 1 && q.size() == 0) begin
        mmode = 2; pads_left = 64;
      end
      e_busy  = (mmode != 0) || done;
      e_ready = (mmode == 0) && !done && (q.size() < 4);
      e_fill  = mfill;
      e_tap   = e_busy ? 4'b0000 : {mfill >= 64, mfill >= 48, mfill >= 32, mfill >= 16};
    end
  end

  // Monitor: event counters and per-cycle model comparison.
  bit mon_en = 0;
  int n_shift = 0, n_pad = 0, n_busy = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (shift) n_shift++;
      if (shift && busy && sr_in == 8'h00) n_pad++;
      if (busy) n_busy++;
      check("m_shift", shift, e_shift);
      if (e_shift) check("m_sr_in", sr_in, e_sr);
      check("m_fill", fill_cnt, e_fill);
      check("m_tap", tap_valid, e_tap);
      check("m_busy", busy, e_busy);
      check("m_ready", in_ready, e_ready);
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 0; flush = 0; hold = 0;
    rst_n = 0;
    step(); step();
    check("rst_shift", shift, 0);
    check("rst_fill", fill_cnt, 0);
    check("rst_tap", tap_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", in_ready, 0);
    check("rst_sr_in", sr_in, 0);
    rst_n = 1;
    step();
    check("ready_after_rst", in_ready, 1);
  endtask

  task automatic send(input logic [7:0] b);
    int t;
    in_data = b;
    in_valid = 1;
    t = 0;
    while (!in_ready && t < 200) begin
      step();
      t++;
    end
    if (t >= 200) check("send_timeout", 0, 1);
    step();
    in_valid = 0;
  endtask

  task automatic wait_not_busy(input string name);
    int t;
    t = 0;
    while (busy && t < 500) begin
      step();
      t++;
    end
    if (t >= 500) check(name, 0, 1);
  endtask

  typedef struct {
    int         nbytes;
    int         exp_fill;
    logic [3:0] exp_tap;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int b0, bp, bs, bb, p1, t;

    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, bp, bs, bb, p1, t;

    vecs[0] = '{1,  1,  4'b0000};
    vecs[1] = '{15, 15, 4'b0000};
    vecs[2] = '{16, 16, 4'b0001};
    vecs[3] = '{31, 31, 4'b0001};
    vecs[4] = '{32, 32, 4'b0011};
    vecs[5] = '{47, 47, 4'b0011};
    vecs[6] = '{48, 48, 4'b0111};
    vecs[7] = '{63, 63, 4'b0111};
    vecs[8] = '{64, 64, 4'b1111};
    vecs[9] = '{74, 64, 4'b1111};

    do_reset();
    mon_en = 1;

    // Fill count / tap thresholds, streaming 0x01, 0x02, ...
    for (int v = 0; v < 10; v++) begin
      do_reset();
      b0 = n_shift;
      for (int i = 0; i < vecs[v].nbytes; i++) send(8'(i + 1));
      repeat (6) step();
      check("tbl_fill", fill_cnt, vecs[v].exp_fill);
      check("tbl_tap", tap_valid, vecs[v].exp_tap);
      check("tbl_shifts", n_shift - b0, vecs[v].nbytes);
    end

    // Latency: accept at edge N, shift visible after edge N+1.
    do_reset();
    in_data = 8'h3C; in_valid = 1;
    step();
    in_valid = 0;
    check("lat_n", shift, 0);
    step();
    check("lat_n1_shift", shift, 1);
    check("lat_n1_data", sr_in, 8'h3C);
    check("lat_n1_fill", fill_cnt, 1);

    // Fill FIFO under hold, then release.
    do_reset();
    hold = 1;
    b0 = n_shift;
    for (int i = 0; i < 4; i++) send(8'(8'h10 + i));
    check("hold_full_ready", in_ready, 0);
    repeat (3) step();
    check("hold_no_shift", n_shift - b0, 0);
    hold = 0;
    repeat (6) step();
    check("hold_release_shifts", n_shift - b0, 4);
    check("hold_release_ready", in_ready, 1);

    // 20 bytes, flush with a 21st byte, hold mid-PAD, second flush ignored.
    do_reset();
    for (int i = 0; i < 20; i++) send(8'(i + 1));
    repeat (4) step();
    check("pre_flush_fill", fill_cnt, 20);
    in_data = 8'd21; in_valid = 1; flush = 1;
    step();
    in_valid = 0; flush = 0;
    check("flush_busy_rise", busy, 1);
    check("flush_ready_fall", in_ready, 0);
    bp = n_pad; bs = n_shift;
    step();
    check("byte21_shift", shift, 1);
    check("byte21_data", sr_in, 21);
    check("byte21_fill", fill_cnt, 21);
    t = 0;
    while (n_pad - bp < 20 && t < 200) begin step(); t++; end
    if (t >= 200) check("pad20_timeout", 0, 1);
    hold = 1;
    p1 = n_pad - bp;
    step();
    flush = 1;
    step();
    flush = 0;
    repeat (3) step();
    check("pad_frozen", n_pad - bp, p1);
    hold = 0;
    wait_not_busy("pad_end_timeout");
    check("pad_total", n_pad - bp, 64);
    check("flush_total_shifts", n_shift - bs, 65);
    check("post_flush_fill", fill_cnt, 0);
    check("post_flush_busy", busy, 0);
    check("post_flush_ready", in_ready, 1);
    repeat (3) step();
    check("post_flush_quiet", n_shift - bs, 65);

    // Flush with empty FIFO and fill_cnt 0 is ignored.
    do_reset();
    bs = n_shift; bb = n_busy;
    flush = 1;
    step();
    flush = 0;
    repeat (10) step();
    check("empty_flush_busy", n_busy - bb, 0);
    check("empty_flush_shift", n_shift - bs, 0);

    // Reset during PAD after 30 pad shifts.
    do_reset();
    send(8'h77);
    repeat (3) step();
    flush = 1;
    step();
    flush = 0;
    bp = n_pad;
    t = 0;
    while (n_pad - bp < 30 && t < 200) begin step(); t++; end
    if (t >= 200) check("pad30_timeout", 0, 1);
    #2;
    rst_n = 0;
    #1;
    check("midpad_rst_shift", shift, 0);
    check("midpad_rst_sr_in", sr_in, 0);
    check("midpad_rst_fill", fill_cnt, 0);
    check("midpad_rst_tap", tap_valid, 0);
    check("midpad_rst_busy", busy, 0);
    check("midpad_rst_ready", in_ready, 0);
    step(); step();
    rst_n = 1;
    step();
    bs = n_shift;
    send(8'hA5);
    step();
    check("a5_shift", shift, 1);
    check("a5_data", sr_in, 8'hA5);
    repeat (4) step();
    check("a5_one_pulse", n_shift - bs, 1);
    check("a5_fill", fill_cnt, 1);

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      in_valid = ($urandom_range(0, 99) < 60);
      in_data  = 8'($urandom);
      hold     = ($urandom_range(0, 99) < 15);
      flush    = ($urandom_range(0, 99) < 2);
      step();
    end
    in_valid = 0; hold = 0; flush = 0;
    repeat (8) step();
    wait_not_busy("rand_end_timeout");
    repeat (8) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
